// File: rtl/hack_cpu_stall.sv
// Hack CPU core with parametrised widths, valid-gated fetch and data read,
// self-loop halt detection and a saturating retired-instruction counter.
module hack_cpu_stall #(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 15,
  parameter int PC_W        = 15,
  parameter int HALT_DETECT = 1,
  parameter int COUNT_W     = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   instruction,
  input  logic               instr_valid,
  input  logic [WIDTH-1:0]   inM,
  input  logic               inM_valid,
  output logic [WIDTH-1:0]   outM,
  output logic               writeM,
  output logic [ADDR_W-1:0]  addressM,
  output logic [PC_W-1:0]    pc,
  output logic [WIDTH-1:0]   d_out,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_d;
  logic [PC_W-1:0]    r_pc;
  logic [COUNT_W-1:0] r_cnt;

  logic             w_is_c;
  logic             w_abit;
  logic [5:0]       w_cc;
  logic [2:0]       w_dst;
  logic [2:0]       w_jmp;
  logic             w_stall;
  logic             w_exec;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_alu;
  logic             w_zr;
  logic             w_ng;
  logic             w_take;
  logic             w_halt;
  logic [WIDTH-1:0] w_aval;

  assign w_is_c  = instruction[WIDTH-1];
  assign w_abit  = instruction[12];
  assign w_cc    = instruction[11:6];
  assign w_dst   = instruction[5:3];
  assign w_jmp   = instruction[2:0];
  assign w_aval  = {1'b0, instruction[WIDTH-2:0]};

  // A C-instruction reading M must wait for valid data; reset blocks side effects
  assign w_stall = ~instr_valid | (w_is_c & w_abit & ~inM_valid);
  assign w_exec  = reset & (r_state == S_RUN) & ~w_stall;

  // Hack ALU: x = D, y = A or M
  always_comb begin
    w_x = r_d;
    w_y = w_abit ? inM : r_a;
    if (w_cc[5]) w_x = '0;
    if (w_cc[4]) w_x = ~w_x;
    if (w_cc[3]) w_y = '0;
    if (w_cc[2]) w_y = ~w_y;
    w_f   = w_cc[1] ? (w_x + w_y) : (w_x & w_y);
    w_alu = w_cc[0] ? ~w_f : w_f;
  end

  assign w_zr   = (w_alu == '0);
  assign w_ng   = w_alu[WIDTH-1];
  assign w_take = w_is_c & ((w_jmp[2] & w_ng) |
                            (w_jmp[1] & w_zr) |
                            (w_jmp[0] & ~w_ng & ~w_zr));

  assign w_halt = w_exec & (HALT_DETECT != 0) & w_is_c &
                  (w_jmp == 3'b111) & (r_a[PC_W-1:0] == r_pc);

  // Next state: a self-jump parks the core until reset
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_RUN:    if (w_halt) w_state_nx = S_HALTED;
      S_HALTED: w_state_nx = S_HALTED;
      default:  w_state_nx = S_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_state_nx;
  end

  // Architectural registers advance only on an executing cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_d   <= '0;
      r_pc  <= '0;
      r_cnt <= '0;
    end else if (w_exec) begin
      if (!w_is_c)      r_a <= w_aval;
      else if (w_dst[2]) r_a <= w_alu;
      if (w_is_c && w_dst[1]) r_d <= w_alu;
      r_pc <= w_take ? r_a[PC_W-1:0] : r_pc + PC_W'(1);
      if (r_cnt != '1) r_cnt <= r_cnt + COUNT_W'(1);
    end
  end

  assign outM     = w_alu;
  assign writeM   = w_exec & w_is_c & w_dst[0];
  assign addressM = r_a[ADDR_W-1:0];
  assign pc       = r_pc;
  assign d_out    = r_d;
  assign halted   = (r_state == S_HALTED);
  assign retired  = r_cnt;

endmodule
